// File: rtl/mem_arbiter.sv
// Two-master arbiter for the memory-map port: master 0 has priority, and locked bursts are supported.
// Read data is routed back to the master that issued the read. Define ARB_STARVE_GUARD_EN to add a master-1 starvation guard.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 16,
    parameter int WAIT_MAX = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              m0Req,
    input  logic                              m0Lock,
    input  logic [ADDR_W-1:0]                 m0Addr,
    input  logic [DATA_W-1:0]                 m0Write,
    input  logic                              m0We,
    output logic                              m0Gnt,
    output logic [DATA_W-1:0]                 m0Read,
    output logic                              m0Valid,
    input  logic                              m1Req,
    input  logic                              m1Lock,
    input  logic [ADDR_W-1:0]                 m1Addr,
    input  logic [DATA_W-1:0]                 m1Write,
    input  logic                              m1We,
    output logic                              m1Gnt,
    output logic [DATA_W-1:0]                 m1Read,
    output logic                              m1Valid,
    output logic [ADDR_W-1:0]                 memAddr,
    output logic [DATA_W-1:0]                 memWrite,
    output logic                              memWe,
    output logic                              memRe,
    input  logic                              memReady,
    input  logic [DATA_W-1:0]                 memRead,
    output logic [1:0]                        dbgOwner,
    output logic [$clog2(WAIT_MAX+1)-1:0]     dbgWait
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

    owner_t owner;
    logic   sel0, sel1, starve, gnt, selWe;
    logic   rdPend, lastReader;

`ifdef ARB_STARVE_GUARD_EN
    logic [CW-1:0] waitCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= '0;
        end else if (m1Gnt) begin
            waitCnt <= '0;
        end else if (m1Req && waitCnt != CW'(WAIT_MAX)) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign starve  = (waitCnt == CW'(WAIT_MAX));
    assign dbgWait = waitCnt;
`else
    assign starve  = 1'b0;
    assign dbgWait = '0;
`endif

    // A lock owner excludes the other master; the guard only acts when nobody owns the port.
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        case (owner)
            OWN0:    sel0 = m0Req;
            OWN1:    sel1 = m1Req;
            default: begin
                if (starve && m1Req) sel1 = 1'b1;
                else if (m0Req)      sel0 = 1'b1;
                else if (m1Req)      sel1 = 1'b1;
            end
        endcase
    end

    // Gating with rst drops the grants and strobes as soon as reset asserts.
    assign m0Gnt    = sel0 && memReady && rst;
    assign m1Gnt    = sel1 && memReady && rst;
    assign gnt      = m0Gnt || m1Gnt;
    assign selWe    = sel1 ? m1We : m0We;
    assign memAddr  = sel1 ? m1Addr : m0Addr;
    assign memWrite = sel1 ? m1Write : m0Write;
    assign memWe    = gnt && selWe;
    assign memRe    = gnt && !selWe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= NONE;
        end else if (m0Gnt) begin
            owner <= m0Lock ? OWN0 : NONE;
        end else if (m1Gnt) begin
            owner <= m1Lock ? OWN1 : NONE;
        end else if ((owner == OWN0 && !m0Req) || (owner == OWN1 && !m1Req)) begin
            owner <= NONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPend     <= 1'b0;
            lastReader <= 1'b0;
        end else begin
            rdPend <= memRe;
            if (memRe) lastReader <= m1Gnt;
        end
    end

    assign m0Valid  = rdPend && !lastReader;
    assign m1Valid  = rdPend && lastReader;
    assign m0Read   = memRead;
    assign m1Read   = memRead;
    assign dbgOwner = owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic checked against a rule-level model.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;
  localparam int WAIT_MAX = 8;
  localparam int CW = $clog2(WAIT_MAX + 1);
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic m0Req, m0Lock, m0We, m0Gnt, m0Valid;
  logic m1Req, m1Lock, m1We, m1Gnt, m1Valid;
  logic [ADDR_W-1:0] m0Addr, m1Addr, memAddr;
  logic [DATA_W-1:0] m0Write, m1Write, m0Read, m1Read, memWrite, memRead;
  logic memWe, memRe, memReady;
  logic [1:0] dbgOwner;
  logic [CW-1:0] dbgWait;

  int total = 0;
  int bad = 0;

  // Model state: owner is -1 for nobody, otherwise the owning master index.
  int m_owner = -1;
  int m_wait = 0;
  bit m_pend = 0;
  int m_who = 0;
  bit last_g0, last_g1;
  bit dut_g0, dut_g1, dut_we;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0Req(m0Req), .m0Lock(m0Lock), .m0Addr(m0Addr), .m0Write(m0Write), .m0We(m0We),
    .m0Gnt(m0Gnt), .m0Read(m0Read), .m0Valid(m0Valid),
    .m1Req(m1Req), .m1Lock(m1Lock), .m1Addr(m1Addr), .m1Write(m1Write), .m1We(m1We),
    .m1Gnt(m1Gnt), .m1Read(m1Read), .m1Valid(m1Valid),
    .memAddr(memAddr), .memWrite(memWrite), .memWe(memWe), .memRe(memRe),
    .memReady(memReady), .memRead(memRead),
    .dbgOwner(dbgOwner), .dbgWait(dbgWait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    int s;
    bit eg0, eg1, ewe;
    @(negedge clk);
    s = -1;
    if (m_owner == 0) begin
      if (m0Req) s = 0;
    end else if (m_owner == 1) begin
      if (m1Req) s = 1;
    end else if (GUARD && m_wait == WAIT_MAX && m1Req) s = 1;
    else if (m0Req) s = 0;
    else if (m1Req) s = 1;
    eg0 = (s == 0) && memReady;
    eg1 = (s == 1) && memReady;
    ewe = (s == 1) ? m1We : m0We;
    check("m0Gnt", m0Gnt, eg0);
    check("m1Gnt", m1Gnt, eg1);
    check("memAddr", memAddr, (s == 1) ? m1Addr : m0Addr);
    check("memWrite", memWrite, (s == 1) ? m1Write : m0Write);
    check("memWe", memWe, (eg0 || eg1) && ewe);
    check("memRe", memRe, (eg0 || eg1) && !ewe);
    check("m0Valid", m0Valid, m_pend && m_who == 0);
    check("m1Valid", m1Valid, m_pend && m_who == 1);
    if (m_pend && m_who == 0) check("m0Read", m0Read, memRead);
    if (m_pend && m_who == 1) check("m1Read", m1Read, memRead);
    check("owner", dbgOwner, (m_owner < 0) ? 0 : m_owner + 1);
    check("waitCnt", dbgWait, m_wait);
    last_g0 = eg0;
    last_g1 = eg1;
    dut_g0 = m0Gnt;
    dut_g1 = m1Gnt;
    dut_we = memWe;
    @(posedge clk);
    m_pend = (eg0 || eg1) && !ewe;
    m_who = eg1 ? 1 : 0;
    if (eg0) m_owner = m0Lock ? 0 : -1;
    else if (eg1) m_owner = m1Lock ? 1 : -1;
    else if ((m_owner == 0 && !m0Req) || (m_owner == 1 && !m1Req)) m_owner = -1;
    if (GUARD) begin
      if (eg1) m_wait = 0;
      else if (m1Req && m_wait < WAIT_MAX) m_wait++;
    end
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic lock, input logic [ADDR_W-1:0] addr);
    m0Req = req; m0We = we; m0Lock = lock; m0Addr = addr; m0Write = 16'($urandom);
  endtask

  task automatic set_m1(input logic req, input logic we, input logic lock, input logic [ADDR_W-1:0] addr);
    m1Req = req; m1We = we; m1Lock = lock; m1Addr = addr; m1Write = 16'($urandom);
  endtask

  initial begin
    int g1_cnt, first_g1, we_cnt, we_at;
    rst = 1'b0;
    set_m0(0, 0, 0, '0);
    set_m1(0, 0, 0, '0);
    memReady = 1'b1;
    memRead = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst m0Gnt", m0Gnt, 0);
    check("rst m1Valid", m1Valid, 0);
    check("rst owner", dbgOwner, 0);
    rst = 1'b1;

    // Single read by master 1, data returned the following cycle.
    set_m1(1, 0, 0, 32'hD000_0010);
    cycle();
    check("read gnt", dut_g1, 1);
    set_m1(0, 0, 0, '0);
    memRead = 16'h1234;
    cycle();

    // Locked burst by master 1; master 0 joins after the first beat and waits.
    g1_cnt = 0;
    set_m1(1, 1, 1, 32'hFFFF_F001);
    cycle();
    g1_cnt += int'(dut_g1);
    set_m0(1, 1, 0, 32'h0000_0100);
    set_m1(1, 1, 1, 32'hFFFF_F002);
    cycle();
    g1_cnt += int'(dut_g1);
    set_m1(1, 1, 0, 32'hFFFF_F003);
    cycle();
    g1_cnt += int'(dut_g1);
    check("burst m1 beats", g1_cnt, 3);
    set_m1(0, 0, 0, '0);
    cycle();
    check("burst m0 after", dut_g0, 1);

    // memReady stall during a master 0 write.
    set_m0(1, 1, 0, 32'h0000_0200);
    we_cnt = 0;
    we_at = -1;
    for (int k = 0; k < 3; k++) begin
      memReady = (k == 2);
      cycle();
      if (dut_we) begin
        we_cnt++;
        we_at = k;
      end
    end
    check("stall we count", we_cnt, 1);
    check("stall we cycle", we_at, 2);
    memReady = 1'b1;

    // Master 0 requests continuously; master 1 only wins through the guard.
    first_g1 = -1;
    set_m1(1, 0, 0, 32'h0000_0300);
    for (int k = 0; k < 12; k++) begin
      set_m0(1, 1, 0, 32'h0000_0400 + k);
      cycle();
      if (dut_g1 && first_g1 < 0) begin
        first_g1 = k;
        set_m1(0, 0, 0, '0);
      end
    end
    check("starve grant cycle", first_g1, GUARD ? WAIT_MAX : -1);
    set_m0(0, 0, 0, '0);
    set_m1(0, 0, 0, '0);
    cycle();

    // Reset asserted right after a granted, locked master 0 read.
    set_m0(1, 0, 1, 32'h0000_0500);
    cycle();
    set_m0(0, 0, 0, '0);
    rst = 1'b0;
    #1;
    check("midrst m0Valid", m0Valid, 0);
    check("midrst owner", dbgOwner, 0);
    m_pend = 0;
    m_owner = -1;
    m_wait = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    check("post rst m0Valid", m0Valid, 0);

    // Randomized traffic; each master holds its command until granted.
    last_g0 = 1;
    last_g1 = 1;
    for (int i = 0; i < 500; i++) begin
      if (!m0Req || last_g0)
        set_m0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), $urandom);
      if (!m1Req || last_g1)
        set_m1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), $urandom);
      memReady = 1'($urandom_range(0, 4) != 0);
      memRead = 16'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
